// File: rtl/block_transfer_seq_if.sv
// Bus bundle for block_transfer_seq: request inputs, register-file ports, memory ports and status.
// The sequencer connects through the slave modport; the requesting/environment side uses master.
interface block_transfer_seq_if #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic                  is_load;
  logic [NUM_REGS-1:0]   reg_list;
  logic [WORD_SIZE-1:0]  base_in;
  logic                  up;
  logic                  pre;
  logic                  wb;
  logic [ADDR_WIDTH-1:0] base_idx;

  logic [ADDR_WIDTH-1:0] rf_read_addr;
  logic [WORD_SIZE-1:0]  rf_read_data;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_write_addr;
  logic [WORD_SIZE-1:0]  rf_write_data;

  logic                  mem_req;
  logic                  mem_we;
  logic [WORD_SIZE-1:0]  mem_addr;
  logic [WORD_SIZE-1:0]  mem_wdata;
  logic                  mem_ack;
  logic [WORD_SIZE-1:0]  mem_rdata;

  logic                  busy;
  logic                  done;

  modport master (
    output start, is_load, reg_list, base_in, up, pre, wb, base_idx,
    output rf_read_data, mem_ack, mem_rdata,
    input  rf_read_addr, rf_we, rf_write_addr, rf_write_data,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    input  start, is_load, reg_list, base_in, up, pre, wb, base_idx,
    input  rf_read_data, mem_ack, mem_rdata,
    output rf_read_addr, rf_we, rf_write_addr, rf_write_data,
    output mem_req, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/block_transfer_seq.sv
// Block load/store sequencer: walks a register list at consecutive word addresses, one transfer per mem_ack.
// Define BTS_BASE_WRITEBACK_EN to add the WBACK state that writes the updated base back to the register file.
module block_transfer_seq #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  block_transfer_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
`ifdef BTS_BASE_WRITEBACK_EN
    WBACK = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t                state_reg;
  logic [NUM_REGS-1:0]   remaining_reg;
  logic [WORD_SIZE-1:0]  addr_reg;
  logic                  is_load_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  mem_req_reg;
  logic                  mem_we_reg;

`ifdef BTS_BASE_WRITEBACK_EN
  logic                  wb_reg;
  logic [ADDR_WIDTH-1:0] base_idx_reg;
  logic [WORD_SIZE-1:0]  final_base_reg;
  logic                  wb_suppress_reg;
  logic [WORD_SIZE-1:0]  final_base;
`else
  wire unused_wb_inputs = &{1'b0, bus.wb, bus.base_idx};
`endif

  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [NUM_REGS-1:0]   remaining_after;
  logic [WORD_SIZE-1:0]  list_count;
  logic [WORD_SIZE-1:0]  span;
  logic [WORD_SIZE-1:0]  start_addr;
  logic                  ack_fire;

  // Lowest set bit of the pending list is the register being transferred.
  always_comb begin
    cur_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (remaining_reg[i]) cur_idx = ADDR_WIDTH'(i);
    end
  end

  assign remaining_after = remaining_reg & (remaining_reg - NUM_REGS'(1));

  always_comb begin
    list_count = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      list_count = list_count + WORD_SIZE'(bus.reg_list[i]);
    end
  end

  assign span = list_count << 2;

  // Decrementing modes still transfer upwards, starting from the lowest address of the block.
  always_comb begin
    case ({bus.up, bus.pre})
      2'b11:   start_addr = bus.base_in + WORD_SIZE'(4);
      2'b10:   start_addr = bus.base_in;
      2'b01:   start_addr = bus.base_in - span;
      default: start_addr = bus.base_in - span + WORD_SIZE'(4);
    endcase
  end

`ifdef BTS_BASE_WRITEBACK_EN
  assign final_base = bus.up ? (bus.base_in + span) : (bus.base_in - span);
`endif

  assign ack_fire = mem_req_reg & bus.mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      remaining_reg   <= '0;
      addr_reg        <= '0;
      is_load_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
`ifdef BTS_BASE_WRITEBACK_EN
      wb_reg          <= 1'b0;
      base_idx_reg    <= '0;
      final_base_reg  <= '0;
      wb_suppress_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            is_load_reg   <= bus.is_load;
            remaining_reg <= bus.reg_list;
            addr_reg      <= start_addr;
`ifdef BTS_BASE_WRITEBACK_EN
            wb_reg          <= bus.wb;
            base_idx_reg    <= bus.base_idx;
            final_base_reg  <= final_base;
            wb_suppress_reg <= bus.is_load & bus.reg_list[bus.base_idx];
`endif
            if (bus.reg_list == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg   <= XFER;
              busy_reg    <= 1'b1;
              mem_req_reg <= 1'b1;
              mem_we_reg  <= ~bus.is_load;
            end
          end
        end
        XFER: begin
          if (bus.mem_ack) begin
            addr_reg      <= addr_reg + WORD_SIZE'(4);
            remaining_reg <= remaining_after;
            if (remaining_after == '0) begin
              mem_req_reg <= 1'b0;
              mem_we_reg  <= 1'b0;
`ifdef BTS_BASE_WRITEBACK_EN
              if (wb_reg) begin
                state_reg <= WBACK;
              end else begin
                state_reg <= DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
`else
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
`endif
            end
          end
        end
`ifdef BTS_BASE_WRITEBACK_EN
        WBACK: begin
          state_reg <= DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
`endif
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic                  rf_we_c;
  logic [ADDR_WIDTH-1:0] rf_write_addr_c;
  logic [WORD_SIZE-1:0]  rf_write_data_c;

  // Load data is written in the ack cycle itself; a loaded base register beats the writeback.
  always_comb begin
    rf_we_c         = 1'b0;
    rf_write_addr_c = '0;
    rf_write_data_c = '0;
    if (ack_fire && is_load_reg) begin
      rf_we_c         = 1'b1;
      rf_write_addr_c = cur_idx;
      rf_write_data_c = bus.mem_rdata;
    end
`ifdef BTS_BASE_WRITEBACK_EN
    if (state_reg == WBACK && !wb_suppress_reg) begin
      rf_we_c         = 1'b1;
      rf_write_addr_c = base_idx_reg;
      rf_write_data_c = final_base_reg;
    end
`endif
  end

  assign bus.rf_we         = rf_we_c;
  assign bus.rf_write_addr = rf_write_addr_c;
  assign bus.rf_write_data = rf_write_data_c;
  assign bus.rf_read_addr  = cur_idx;
  assign bus.mem_req       = mem_req_reg;
  assign bus.mem_we        = mem_we_reg;
  assign bus.mem_addr      = mem_req_reg ? addr_reg : '0;
  assign bus.mem_wdata     = (mem_req_reg && mem_we_reg) ? bus.rf_read_data : '0;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;

endmodule

// File: tb/tb_block_transfer_seq.sv
// Self-checking bench for block_transfer_seq: directed table, reset-abort sequence and randomized
// transfers compared against a list/arithmetic model of the expected memory and register traffic.
`timescale 1ns/1ps
module tb_block_transfer_seq;
  localparam int WS = 32;
  localparam int NR = 16;
  localparam int AW = 4;
`ifdef BTS_BASE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_transfer_seq_if #(.WORD_SIZE(WS), .NUM_REGS(NR), .ADDR_WIDTH(AW)) bus ();

  block_transfer_seq #(.WORD_SIZE(WS), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rf_val(input logic [31:0] seed, input int idx);
    return seed ^ (32'(idx) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Register file and memory models around the DUT
  logic [31:0] rf [NR];
  logic [31:0] rf_seed = 32'h0;
  logic        rf_load = 1'b0;
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < NR; i++) rf[i] <= rf_val(rf_seed, i);
    end else if (bus.rf_we) begin
      rf[bus.rf_write_addr] <= bus.rf_write_data;
    end
  end
  assign bus.rf_read_data = rf[bus.rf_read_addr];
  assign bus.mem_rdata    = mem_val(bus.mem_addr);

  // Acknowledge generator: wait states per transfer, optional noise while no request is pending
  int wait_max   = 0;
  bit wait_fixed = 1'b1;
  bit ack_noise  = 1'b0;
  int wcnt       = 0;
  int wcur       = 0;
  int stall_cnt  = 0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      bus.mem_ack = 1'b0;
    end else if (bus.mem_req) begin
      if (wcnt >= wcur) begin
        bus.mem_ack = 1'b1;
        wcnt = 0;
        wcur = wait_fixed ? wait_max : int'($urandom_range(wait_max));
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
        stall_cnt++;
      end
    end else begin
      bus.mem_ack = ack_noise ? 1'($urandom_range(1)) : 1'b0;
      wcnt = 0;
    end
  end

  typedef struct {logic [31:0] addr; logic we; logic [31:0] data;} mem_ev_t;
  typedef struct {logic [3:0] addr; logic [31:0] data;} rf_ev_t;
  mem_ev_t mem_q[$];
  rf_ev_t  rf_q[$];
  int          stab_err = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  bit          prev_wait = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_req) begin
        if (prev_wait && (bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_wdata)) stab_err++;
        prev_addr  = bus.mem_addr;
        prev_wdata = bus.mem_wdata;
        prev_wait  = !bus.mem_ack;
        if (bus.mem_ack) mem_q.push_back('{bus.mem_addr, bus.mem_we, bus.mem_wdata});
      end else begin
        prev_wait = 1'b0;
      end
      if (bus.rf_we) rf_q.push_back('{bus.rf_write_addr, bus.rf_write_data});
    end
  end

  task automatic load_rf();
    @(posedge clk); #2;
    rf_seed = $urandom;
    rf_load = 1'b1;
    @(posedge clk); #2;
    rf_load = 1'b0;
  endtask

  // One complete transfer; every observation is compared with the model derived from the request.
  task automatic run_xfer(input logic ld, input logic [15:0] list, input logic [31:0] base,
                          input bit up_i, input bit pre_i, input bit wb_i, input logic [3:0] bidx,
                          input int waits, input bit fixed, input bit glitch,
                          output int n_mem, output logic [31:0] first_a, output logic [31:0] last_a,
                          output int n_rfw, output int done_cyc);
    int n, k, cyc, exp_done;
    bit got_done, busy_ok;
    logic [31:0] low, ea;
    rf_ev_t rf_exp[$];
    load_rf();
    mem_q.delete(); rf_q.delete();
    stab_err = 0; stall_cnt = 0;
    wait_max = waits; wait_fixed = fixed; wcnt = 0;
    wcur = fixed ? waits : int'($urandom_range(waits));
    bus.start = 1'b1; bus.is_load = ld; bus.reg_list = list; bus.base_in = base;
    bus.up = up_i; bus.pre = pre_i; bus.wb = wb_i; bus.base_idx = bidx;
    @(posedge clk); #2;
    if (glitch) begin
      bus.reg_list = ~list; bus.is_load = ~ld; bus.base_in = ~base; bus.up = ~up_i;
    end else begin
      bus.start = 1'b0;
    end
    cyc = 0; got_done = 1'b0; busy_ok = 1'b1;
    while (cyc < 400 && !got_done) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (bus.done) begin
        got_done = 1'b1;
        if (bus.busy) busy_ok = 1'b0;
      end else if (!bus.busy) begin
        busy_ok = 1'b0;
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);

    n = $countones(list);
    low = up_i ? base + (pre_i ? 32'd4 : 32'd0) : base - 32'(4 * n) + (pre_i ? 32'd0 : 32'd4);
    k = 0;
    for (int i = 0; i < NR; i++) begin
      if (list[i]) begin
        ea = low + 32'(4 * k);
        if (k < mem_q.size()) begin
          check("mem_addr", mem_q[k].addr, ea);
          check("mem_we", 32'(mem_q[k].we), 32'(!ld));
          if (!ld) check("mem_wdata", mem_q[k].data, rf_val(rf_seed, i));
        end
        if (ld) rf_exp.push_back('{4'(i), mem_val(ea)});
        k++;
      end
    end
    check("mem_count", 32'(mem_q.size()), 32'(n));
    if (WB_EN && wb_i && n > 0 && !(ld && list[bidx]))
      rf_exp.push_back('{bidx, up_i ? base + 32'(4 * n) : base - 32'(4 * n)});
    check("rf_count", 32'(rf_q.size()), 32'(rf_exp.size()));
    for (int i = 0; i < rf_exp.size() && i < rf_q.size(); i++) begin
      check("rf_waddr", 32'(rf_q[i].addr), 32'(rf_exp[i].addr));
      check("rf_wdata", rf_q[i].data, rf_exp[i].data);
    end
    exp_done = (n == 0) ? 1 : n + stall_cnt + 1 + ((WB_EN && wb_i) ? 1 : 0);
    check("done_cycle", 32'(cyc), 32'(exp_done));
    check("busy_window", 32'(busy_ok), 32'd1);
    check("addr_stable", 32'(stab_err), 32'd0);

    n_mem   = mem_q.size();
    first_a = (n_mem > 0) ? mem_q[0].addr : 32'h0;
    last_a  = (n_mem > 0) ? mem_q[n_mem-1].addr : 32'h0;
    n_rfw   = rf_q.size();
    done_cyc = cyc;
    $display("[TB] xfer load=%0d list=0x%04h base=0x%08h up=%0d pre=%0d wb=%0d n=%0d stalls=%0d done@%0d",
             ld, list, base, up_i, pre_i, wb_i, n, stall_cnt, cyc);
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] list;
    logic [31:0] base;
    bit          up, pre, wb;
    logic [3:0]  bidx;
    int          waits;
    int          exp_n;
    logic [31:0] exp_first, exp_last;
    int          exp_done;
    int          exp_rfw;
  } vec_t;

  vec_t vec [8];

  initial begin
    int n_mem, n_rfw, dcyc, bad;
    logic [31:0] fa, la;
    logic [15:0] rl;

    vec[0] = '{1'b0, 16'h0013, 32'h0000_0100, 1, 0, 0, 4'd0,  0, 3,  32'h100, 32'h108, 4, 0};
    vec[1] = '{1'b1, 16'h8006, 32'h0000_0200, 0, 1, 1, 4'd13, 0, 3,  32'h1F4, 32'h1FC,
               WB_EN ? 5 : 4, WB_EN ? 4 : 3};
    vec[2] = '{1'b0, 16'h0013, 32'h0000_0100, 1, 0, 0, 4'd0,  3, 3,  32'h100, 32'h108, 13, 0};
    vec[3] = '{1'b1, 16'h0000, 32'h0000_0300, 1, 0, 1, 4'd2,  0, 0,  32'h0,   32'h0,   1, 0};
    vec[4] = '{1'b1, 16'h0008, 32'h0000_0040, 1, 0, 1, 4'd3,  0, 1,  32'h40,  32'h40,  WB_EN ? 3 : 2, 1};
    vec[5] = '{1'b0, 16'hFFFF, 32'h0000_1000, 1, 1, 1, 4'd2,  0, 16, 32'h1004, 32'h1040,
               WB_EN ? 18 : 17, WB_EN ? 1 : 0};
    vec[6] = '{1'b1, 16'h0101, 32'h0000_0080, 0, 0, 1, 4'd5,  0, 2,  32'h7C,  32'h80,
               WB_EN ? 4 : 3, WB_EN ? 3 : 2};
    vec[7] = '{1'b0, 16'h0003, 32'hFFFF_FFFC, 1, 1, 0, 4'd0,  0, 2,  32'h0,   32'h4,   3, 0};

    reset = 1'b1;
    bus.start = 1'b0; bus.is_load = 1'b0; bus.reg_list = '0; bus.base_in = '0;
    bus.up = 1'b0; bus.pre = 1'b0; bus.wb = 1'b0; bus.base_idx = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_rf_read_addr", 32'(bus.rf_read_addr), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_xfer(vec[v].ld, vec[v].list, vec[v].base, vec[v].up, vec[v].pre, vec[v].wb, vec[v].bidx,
               vec[v].waits, 1'b1, 1'b0, n_mem, fa, la, n_rfw, dcyc);
      check($sformatf("tbl%0d_n", v), 32'(n_mem), 32'(vec[v].exp_n));
      if (vec[v].exp_n > 0) begin
        check($sformatf("tbl%0d_first", v), fa, vec[v].exp_first);
        check($sformatf("tbl%0d_last", v), la, vec[v].exp_last);
      end
      check($sformatf("tbl%0d_done", v), 32'(dcyc), 32'(vec[v].exp_done));
      check($sformatf("tbl%0d_rfw", v), 32'(n_rfw), 32'(vec[v].exp_rfw));
    end

    // Reset during the second XFER cycle of a four-register load
    load_rf();
    mem_q.delete(); rf_q.delete();
    wait_max = 0; wait_fixed = 1'b1; wcnt = 0; wcur = 0;
    bus.start = 1'b1; bus.is_load = 1'b1; bus.reg_list = 16'h000F; bus.base_in = 32'h500;
    bus.up = 1'b1; bus.pre = 1'b0; bus.wb = 1'b1; bus.base_idx = 4'd0;
    @(posedge clk); #2;
    bus.start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    check("abort_rf_we", 32'(bus.rf_we), 32'd0);
    check("abort_mem_addr", bus.mem_addr, 32'd0);
    check("abort_rf_wdata", bus.rf_write_data, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rf_we || bus.mem_req || bus.done || bus.busy) bad++;
    end
    check("abort_quiet", 32'(bad), 32'd0);
    check("abort_rf_writes", 32'(rf_q.size()), 32'd1);

    // Randomized transfers with wait states, ack noise and start pulses while busy
    ack_noise = 1'b1;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(3))
        0:       rl = ($urandom_range(2) == 0) ? 16'h0000 : 16'($urandom) & 16'($urandom);
        1:       rl = 16'h1 << $urandom_range(15);
        default: rl = 16'($urandom);
      endcase
      run_xfer(1'($urandom_range(1)), rl,
               ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom,
               1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
               4'($urandom_range(15)), int'($urandom_range(2)), 1'b0, 1'($urandom_range(1)),
               n_mem, fa, la, n_rfw, dcyc);
    end
    ack_noise = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
